// File: rtl/clock_step_ctrl_if.sv
// Board-side signal bundle for the CPU clock-enable controller: raw
// button/switch/halt inputs toward the controller, enable and debug outputs back.
interface clock_step_ctrl_if;
  logic        step_btn;
  logic        run;
  logic        halt;
  logic        enable;
  logic [1:0]  state;
  logic [15:0] cycle_cnt;

  modport master (
    output step_btn,
    output run,
    output halt,
    input  enable,
    input  state,
    input  cycle_cnt
  );

  modport slave (
    input  step_btn,
    input  run,
    input  halt,
    output enable,
    output state,
    output cycle_cnt
  );
endinterface

// File: rtl/clock_step_ctrl.sv
// CPU clock-enable generator: one enable per debounced button press, a divided
// enable stream in run mode, and a hard stop while the CPU reports halt.
module clock_step_ctrl #(
  parameter int unsigned DB_COUNT = 50000,
  parameter int unsigned RUN_DIV  = 4
) (
  input  logic              clk,
  input  logic              reset,
  clock_step_ctrl_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STEP   = 2'b01,
    RUN    = 2'b10,
    HALTED = 2'b11
  } state_t;

  localparam logic [15:0] DB_LAST  = 16'(DB_COUNT - 1);
  localparam logic [7:0]  DIV_LAST = 8'(RUN_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic        step_s1;
  logic        step_s2;
  logic        run_s1;
  logic        run_s2;
  logic        db_level;
  logic [15:0] db_cnt;
  logic        step_req;
  logic [7:0]  div_q;
  logic        enable_q;
  logic        enable_d;
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      run_s1  <= 1'b0;
      run_s2  <= 1'b0;
    end else begin
      step_s1 <= io.step_btn;
      step_s2 <= step_s1;
      run_s1  <= io.run;
      run_s2  <= run_s1;
    end
  end

  // The level only flips after DB_COUNT consecutive disagreeing cycles; a
  // rising flip is latched as a one-cycle step request seen by the FSM next.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_level <= 1'b0;
      db_cnt   <= 16'd0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (step_s2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= step_s2;
          db_cnt   <= 16'd0;
          step_req <= step_s2;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end else begin
        db_cnt <= 16'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
    end
  end

  // Halt always wins, then the run switch, then a step request.
  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.halt)      state_d = HALTED;
        else if (run_s2)  state_d = RUN;
        else if (step_req) state_d = STEP;
      end
      STEP: begin
        state_d = io.halt ? HALTED : IDLE;
      end
      RUN: begin
        if (io.halt)      state_d = HALTED;
        else if (!run_s2) state_d = IDLE;
      end
      HALTED: begin
        if (!io.halt && !run_s2) state_d = IDLE;
      end
    endcase
    // A run enable is only issued if the FSM stays in RUN, so it never
    // appears alongside IDLE or HALTED.
    enable_d = (state_d == STEP) ||
               ((state_q == RUN) && (state_d == RUN) && (div_q == DIV_LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 8'd0;
    end else if (state_q != RUN) begin
      div_q <= 8'd0;
    end else if (div_q == DIV_LAST) begin
      div_q <= 8'd0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else if (enable_q) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign io.enable    = enable_q;
  assign io.state     = state_q;
  assign io.cycle_cnt = cnt_q;

endmodule
